// File: rtl/gravador_senha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gravador_senha_pkg
// Description : Shared definitions for the password programmer and the entry
//               checker. It holds the session state encoding, the digit width,
//               the factory-default password and the button decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package gravador_senha_pkg;

    // Each button press encodes one of four digits.
    localparam int c_LARGURA_DIGITO = 2;

    // Factory password (digits 0,1,2,3). The checker uses the same constant,
    // so both blocks agree on the password after reset.
    localparam logic [7:0] c_SENHA_PADRAO = 8'h1B;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        NOVA     = 2'd1,
        CONFIRMA = 2'd2,
        COMPARA  = 2'd3
    } estado_t;

    typedef struct packed {
        logic                        valida;
        logic [c_LARGURA_DIGITO-1:0] digito;
    } tecla_t;

    // A press is valid only when exactly one button is set. The digit is the
    // index of that button. Chords and empty samples decode as invalid.
    function automatic tecla_t decodifica_botoes(input logic [3:0] botoes);
        tecla_t t;
        t = '0;
        case (botoes)
            4'b0001: t = '{valida: 1'b1, digito: 2'd0};
            4'b0010: t = '{valida: 1'b1, digito: 2'd1};
            4'b0100: t = '{valida: 1'b1, digito: 2'd2};
            4'b1000: t = '{valida: 1'b1, digito: 2'd3};
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gravador_senha_temporizador.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_inatividade
// Description : Inactivity timer. It counts i_tick pulses while i_habilita is
//               high and restarts from zero on i_limpar. It raises o_fim in the
//               cycle where the TIMEOUT_S-th tick arrives.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               i_habilita     - count only while a session is collecting
//               i_limpar       - restart count (valid press)
//               i_tick         - one-cycle 1 Hz pulse
//               o_fim          - terminal pulse (combinational, top registers)
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_inatividade #(
    parameter int TIMEOUT_S = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_habilita,
    input  logic i_limpar,
    input  logic i_tick,
    output logic o_fim
);

    localparam int                   c_LARGURA = $clog2(TIMEOUT_S + 1);
    localparam logic [c_LARGURA-1:0] c_ULTIMO  = c_LARGURA'(TIMEOUT_S - 1);

    logic [c_LARGURA-1:0] r_contagem;
    logic                 w_fim;

    // A clear in the same cycle as a tick wins, so a press always resets the count.
    assign w_fim = i_habilita & i_tick & ~i_limpar & (r_contagem == c_ULTIMO);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_limpar || !i_habilita || w_fim) begin
            r_contagem <= '0;
        end else if (i_tick) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign o_fim = w_fim;

endmodule
`default_nettype wire

// File: rtl/gravador_senha.sv
`default_nettype none
// ============================================================================
// Module      : gravador_senha
// Description : Password programmer. While modo_gravar is held, it collects a
//               new password and then a confirmation from the four buttons. It
//               commits the new password only when both entries match.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               botoes[3:0]       - one-cycle debounced button pulses
//               modo_gravar       - programming-mode switch (level)
//               tick_1hz          - one-cycle 1 Hz pulse
//               senha_armazenada  - stored password, first digit in MSBs
//               gravada           - pulse: new password committed
//               erro_confirmacao  - pulse: confirmation mismatch
//               tempo_esgotado    - pulse: session aborted on inactivity
//               ocupado           - session active
//               fase              - 0 new password, 1 confirmation
//               digitos           - digits accepted in current phase
// Config      : GRAVADOR_TIMEOUT_EN - define to include the inactivity timer.
//               When it is undefined, tick_1hz is ignored and tempo_esgotado
//               stays at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gravador_senha
    import gravador_senha_pkg::*;
#(
    parameter int                       N_DIGITOS    = 4,
    parameter logic [2*N_DIGITOS-1:0]   SENHA_PADRAO = c_SENHA_PADRAO,
    parameter int                       TIMEOUT_S    = 20
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        botoes,
    input  logic                              modo_gravar,
    input  logic                              tick_1hz,
    output logic [2*N_DIGITOS-1:0]            senha_armazenada,
    output logic                              gravada,
    output logic                              erro_confirmacao,
    output logic                              tempo_esgotado,
    output logic                              ocupado,
    output logic                              fase,
    output logic [$clog2(N_DIGITOS+1)-1:0]    digitos
);

    localparam int c_LARGURA_SENHA = c_LARGURA_DIGITO * N_DIGITOS;
    localparam int c_LARGURA_CONT  = $clog2(N_DIGITOS + 1);
    localparam logic [c_LARGURA_CONT-1:0] c_ULTIMO_DIGITO = c_LARGURA_CONT'(N_DIGITOS - 1);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    estado_t                    r_estado;
    logic                       r_modo_ant;
    logic [c_LARGURA_SENHA-1:0] r_buf_nova;
    logic [c_LARGURA_SENHA-1:0] r_buf_conf;
    logic [c_LARGURA_SENHA-1:0] r_senha;
    logic [c_LARGURA_CONT-1:0]  r_digitos;
    logic                       r_gravada;
    logic                       r_erro;
    logic                       r_tempo;
    logic                       r_ocupado;
    logic                       r_fase;

    estado_t                    w_estado_prox;
    logic [c_LARGURA_SENHA-1:0] w_buf_nova_prox;
    logic [c_LARGURA_SENHA-1:0] w_buf_conf_prox;
    logic [c_LARGURA_SENHA-1:0] w_senha_prox;
    logic [c_LARGURA_CONT-1:0]  w_digitos_prox;
    logic                       w_gravada_prox;
    logic                       w_erro_prox;
    logic                       w_tempo_prox;

    tecla_t                     w_tecla;
    logic                       w_subida;
    logic                       w_descida;
    logic                       w_fim_timeout;

    assign w_tecla   = decodifica_botoes(botoes);
    assign w_subida  =  modo_gravar & ~r_modo_ant;
    assign w_descida = ~modo_gravar &  r_modo_ant;

    // ------------------------------------------------------------------------
    // Optional inactivity timer
    // ------------------------------------------------------------------------
`ifdef GRAVADOR_TIMEOUT_EN
    logic w_coletando;
    assign w_coletando = (r_estado == NOVA) || (r_estado == CONFIRMA);

    temporizador_inatividade #(
        .TIMEOUT_S (TIMEOUT_S)
    ) u_temporizador (
        .clk        (clk),
        .reset      (reset),
        .i_habilita (w_coletando),
        .i_limpar   (w_tecla.valida),
        .i_tick     (tick_1hz),
        .o_fim      (w_fim_timeout)
    );
`else
    logic w_tick_unused;
    assign w_tick_unused = tick_1hz;
    assign w_fim_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_estado_prox   = r_estado;
        w_buf_nova_prox = r_buf_nova;
        w_buf_conf_prox = r_buf_conf;
        w_senha_prox    = r_senha;
        w_digitos_prox  = r_digitos;
        w_gravada_prox  = 1'b0;
        w_erro_prox     = 1'b0;
        w_tempo_prox    = 1'b0;

        case (r_estado)
            OCIOSO: begin
                if (w_subida) begin
                    w_estado_prox   = NOVA;
                    w_buf_nova_prox = '0;
                    w_buf_conf_prox = '0;
                    w_digitos_prox  = '0;
                end
            end

            NOVA, CONFIRMA: begin
                // Abort has priority. A press beats a coincident timeout.
                if (w_descida) begin
                    w_estado_prox   = OCIOSO;
                    w_buf_nova_prox = '0;
                    w_buf_conf_prox = '0;
                    w_digitos_prox  = '0;
                end else if (w_tecla.valida) begin
                    if (r_estado == NOVA) begin
                        w_buf_nova_prox = (r_buf_nova << c_LARGURA_DIGITO)
                                        | c_LARGURA_SENHA'(w_tecla.digito);
                    end else begin
                        w_buf_conf_prox = (r_buf_conf << c_LARGURA_DIGITO)
                                        | c_LARGURA_SENHA'(w_tecla.digito);
                    end
                    if (r_digitos == c_ULTIMO_DIGITO) begin
                        w_digitos_prox = '0;
                        w_estado_prox  = (r_estado == NOVA) ? CONFIRMA : COMPARA;
                    end else begin
                        w_digitos_prox = r_digitos + 1'b1;
                    end
                end else if (w_fim_timeout) begin
                    w_estado_prox   = OCIOSO;
                    w_tempo_prox    = 1'b1;
                    w_buf_nova_prox = '0;
                    w_buf_conf_prox = '0;
                    w_digitos_prox  = '0;
                end
            end

            COMPARA: begin
                // Single-cycle verdict. modo_gravar is ignored here.
                w_estado_prox = OCIOSO;
                if (r_buf_nova == r_buf_conf) begin
                    w_senha_prox   = r_buf_nova;
                    w_gravada_prox = 1'b1;
                end else begin
                    w_erro_prox    = 1'b1;
                end
                w_buf_nova_prox = '0;
                w_buf_conf_prox = '0;
            end

            default: begin
                w_estado_prox = OCIOSO;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            // Preset high so a switch held through reset is not seen as a rising edge.
            r_modo_ant <= 1'b1;
            r_buf_nova <= '0;
            r_buf_conf <= '0;
            r_senha    <= SENHA_PADRAO;
            r_digitos  <= '0;
            r_gravada  <= 1'b0;
            r_erro     <= 1'b0;
            r_tempo    <= 1'b0;
            r_ocupado  <= 1'b0;
            r_fase     <= 1'b0;
        end else begin
            r_estado   <= w_estado_prox;
            r_modo_ant <= modo_gravar;
            r_buf_nova <= w_buf_nova_prox;
            r_buf_conf <= w_buf_conf_prox;
            r_senha    <= w_senha_prox;
            r_digitos  <= w_digitos_prox;
            r_gravada  <= w_gravada_prox;
            r_erro     <= w_erro_prox;
            r_tempo    <= w_tempo_prox;
            r_ocupado  <= (w_estado_prox != OCIOSO);
            r_fase     <= (w_estado_prox == CONFIRMA) || (w_estado_prox == COMPARA);
        end
    end

    assign senha_armazenada = r_senha;
    assign gravada          = r_gravada;
    assign erro_confirmacao = r_erro;
    assign tempo_esgotado   = r_tempo;
    assign ocupado          = r_ocupado;
    assign fase             = r_fase;
    assign digitos          = r_digitos;

endmodule
`default_nettype wire

// File: doc/gravador_senha.md
# gravador_senha

Password-programming block for the access-control system: the write side of the password that the entry-checking state machine compares against. While the administrator holds the programming mode, it collects a new password from the four buttons and then a confirmation entry. It commits the new value to the stored-password register only when both entries match. Its stored-password output feeds the checker's comparison input, and its status pulses feed the display and LED logic.

## Interface
Parameters:
- `N_DIGITOS`, default 4: password length in button presses.
- `SENHA_PADRAO`, default `8'h1B` (digits 0,1,2,3): reset value of the stored password, width `2*N_DIGITOS`.
- `TIMEOUT_S`, default 20: inactivity limit, counted in `tick_1hz` pulses.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `botoes`  in  4  debounced, one-cycle button pulses; `botoes[k]` encodes digit k.
- `modo_gravar`  in  1  level; administrator programming-mode switch.
- `tick_1hz`  in  1  one-cycle pulse once per second, synchronous to `clk`.
- `senha_armazenada`  out  2*N_DIGITOS  stored password; first digit in the MSBs.
- `gravada`  out  1  one-cycle pulse; new password committed.
- `erro_confirmacao`  out  1  one-cycle pulse; confirmation mismatch, nothing committed.
- `tempo_esgotado`  out  1  one-cycle pulse; session aborted on inactivity.
- `ocupado`  out  1  high while a session is active.
- `fase`  out  1  0 = entering new password, 1 = confirming.
- `digitos`  out  clog2(N_DIGITOS+1)  digits accepted in the current phase, for display.

## Operation
- States: `OCIOSO`, `NOVA`, `CONFIRMA`, `COMPARA`.
- `OCIOSO`:
  - A rising edge of `modo_gravar` starts a session: go to `NOVA` with `digitos`=0 and the timer cleared.
  - A level that is held high never starts a session.
- Valid press: exactly one bit of `botoes` set. The digit is the index of that bit.
  - Zero or multiple bits set is ignored. It accepts no digit and does not reset the timer.
- `NOVA`:
  - Each valid press shifts its digit into the new-password buffer, first digit toward the MSBs, and increments `digitos`.
  - On the N-th digit: go to `CONFIRMA`, with `digitos`=0 and `fase`=1.
- `CONFIRMA`: shifts digits into the confirmation buffer in the same way. On the N-th digit, go to `COMPARA`.
- `COMPARA`: lasts one cycle, then returns to `OCIOSO`.
  - Buffers equal: load `senha_armazenada` from the new-password buffer and pulse `gravada`.
  - Buffers differ: pulse `erro_confirmacao`; `senha_armazenada` is unchanged.
- `modo_gravar` falling in `NOVA` or `CONFIRMA`: silent abort to `OCIOSO`. Buffers are cleared, no pulse is issued and nothing is committed.
- A falling edge during `COMPARA` does not cancel the compare.
- The timer counts `tick_1hz` pulses in `NOVA` and `CONFIRMA` and resets to 0 on every valid press.
  - When the count reaches `TIMEOUT_S`: pulse `tempo_esgotado`, go to `OCIOSO`, discard both buffers.
  - A valid press and a tick in the same cycle: the press wins and the count becomes 0.
- Buffers are cleared on every entry to `NOVA`.

## Timing
- Reset values:
  - State `OCIOSO`.
  - `senha_armazenada`=`SENHA_PADRAO`.
  - `gravada`, `erro_confirmacao`, `tempo_esgotado`, `ocupado`, `fase` all 0.
  - `digitos`=0 and timer=0.
  - The edge-detect register for `modo_gravar` is set to 1, so a switch held high through reset does not start a session.
- A reset asserted mid-session aborts to the reset values immediately; the stored password reverts to `SENHA_PADRAO`.
- `modo_gravar` rises in cycle t: `ocupado`=1 from cycle t+1.
- Press sampled in cycle t: `digitos` is updated in cycle t+1.
- Last confirmation press in cycle t: `COMPARA` in cycle t+1. `gravada` or `erro_confirmacao` is high for exactly cycle t+2, together with the new `senha_armazenada` value and `ocupado`=0.
- All outputs are registered.

## Configuration
- `GRAVADOR_TIMEOUT_EN` defined: the inactivity timer is present as described above.
- `GRAVADOR_TIMEOUT_EN` undefined:
  - The timer is removed and `tick_1hz` is ignored.
  - `tempo_esgotado` is tied to 0.
  - A session ends only by completion, `modo_gravar` falling, or reset.

## Structure
- Shared package holds:
  - The state encoding of `OCIOSO`, `NOVA`, `CONFIRMA` and `COMPARA`.
  - The digit width constant (2).
  - The default `SENHA_PADRAO` value, so the checker and the programmer agree on the reset password.
- One sub-module: `temporizador_inatividade`, a tick counter with clear and a terminal pulse, parameterised by `TIMEOUT_S`. It is instantiated only under `GRAVADOR_TIMEOUT_EN`.

## Test plan
- Reset with defaults: `senha_armazenada`=`8'h1B`; all pulses 0; `ocupado`=0.
- Raise `modo_gravar`, press 3,2,1,0 then 3,2,1,0: `gravada` is high 2 cycles after the last press; `senha_armazenada`=`8'hE4`; `fase` toggles 0→1 after the 4th press.
- Enter 3,2,1,0 then 3,2,1,1: `erro_confirmacao` pulses once; `senha_armazenada` stays `8'h1B`.
- `botoes`=`4'b0011` during `NOVA`: `digitos` is unchanged. The following single presses are accepted normally.
- With the macro defined, enter 2 digits then issue 20 ticks: `tempo_esgotado` pulses on the 20th tick and `ocupado` drops. Repeating with a press coincident with the 20th tick gives no timeout.
- `modo_gravar` held high through reset: the block stays `OCIOSO`. After a fresh rising edge, drop `modo_gravar` mid-`CONFIRMA`: the session aborts with no pulses and the password is unchanged.
